// File: rtl/iter_muldiv32.sv
// Radix-2 iterative multiply/divide unit: one shift-add or restoring-divide step per cycle,
// valid/ready handshakes on request and result, signed and unsigned operands.
module iter_muldiv32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_DIV, OP_REM} op_t;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    op_t                op_q;
    logic               neg_p_q, neg_r_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   result_q;
    logic               div_zero_q;

    op_t              op_in;
    logic             accept, is_div_in, sa, sb, b_zero, ovf, early;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign op_in     = op_t'(op);
    assign accept    = in_valid && (state_q == IDLE);
    assign is_div_in = (op_in == OP_DIV) || (op_in == OP_REM);
    assign sa        = is_signed && a[WIDTH-1];
    assign sb        = is_signed && b[WIDTH-1];
    assign abs_a     = sa ? -a : a;
    assign abs_b     = sb ? -b : b;
    assign b_zero    = (b == '0);
    assign ovf       = is_signed && (a == MIN_VAL) && (b == '1);
    // Divide-by-zero and MIN/-1 have fixed answers, so they skip the engine entirely.
    assign early     = is_div_in && (b_zero || ovf);

    // Multiply: acc holds {partial high, remaining multiplier bits}; add then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc holds {remainder, dividend/quotient}; shift left, trial-subtract the divisor.
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, mcand_q};
    assign div_next  = div_diff[WIDTH]
                     ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_val;
    assign prod = neg_p_q ? -acc_q : acc_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        fix_val = '0;
        unique case (op_q)
            OP_MUL:  fix_val = prod[WIDTH-1:0];
            OP_MULH: fix_val = prod[2*WIDTH-1:WIDTH];
            OP_DIV:  fix_val = neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            OP_REM:  fix_val = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            default: fix_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = early ? DONE : CALC;
            CALC:    if (cnt_q == CNT_W'(1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            op_q       <= OP_MUL;
            neg_p_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            mcand_q    <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (accept) begin
                    op_q       <= op_in;
                    neg_p_q    <= sa ^ sb;
                    neg_r_q    <= sa;
                    cnt_q      <= CNT_W'(WIDTH);
                    div_zero_q <= is_div_in && b_zero;
                    if (is_div_in) begin
                        mcand_q <= abs_b;
                        acc_q   <= {{WIDTH{1'b0}}, abs_a};
                    end else begin
                        mcand_q <= abs_a;
                        acc_q   <= {{WIDTH{1'b0}}, abs_b};
                    end
                    if (early) begin
                        if (b_zero) result_q <= (op_in == OP_DIV) ? '1 : a;
                        else        result_q <= (op_in == OP_DIV) ? MIN_VAL : '0;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    acc_q <= (op_q == OP_DIV || op_q == OP_REM) ? div_next : mul_next;
                end
                FIX:     result_q <= fix_val;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_iter_muldiv32.sv
// Self-checking bench for iter_muldiv32: directed table, randomized ops against an arithmetic
// reference model, plus backpressure and mid-operation reset sequences.
module tb_iter_muldiv32;

    localparam int W = 32;
    localparam int NORMAL_LAT = W + 2;
    localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, DIV = 2'b10, REM = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        div_zero;

    int total = 0;
    int bad = 0;

    iter_muldiv32 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_signed(is_signed), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operand values. Returns {div_zero, result}.
    function automatic logic [32:0] model(input logic [1:0] o, input logic s,
                                          input logic [31:0] x, input logic [31:0] y);
        longint      px, py;
        logic [63:0] p;
        if (o == MUL || o == MULH) begin
            px = s ? longint'($signed(x)) : longint'(x);
            py = s ? longint'($signed(y)) : longint'(y);
            p  = px * py;
            return {1'b0, (o == MUL) ? p[31:0] : p[63:32]};
        end
        if (y == 0) return {1'b1, (o == DIV) ? 32'hFFFF_FFFF : x};
        if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return {1'b0, (o == DIV) ? 32'h8000_0000 : 32'h0};
        if (s) return {1'b0, (o == DIV) ? 32'($signed(x) / $signed(y)) : 32'($signed(x) % $signed(y))};
        return {1'b0, (o == DIV) ? x / y : x % y};
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic s,
                                     input logic [31:0] x, input logic [31:0] y);
        if (o[1] && (y == 0 || (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
        return NORMAL_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one request, wait for the result (bounded), record it and hand it off.
    // lat = number of falling edges after the accept edge at which out_valid is first seen.
    task automatic do_op(input logic [1:0] o, input logic s, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic dz, output int lat, output logic busy_hi);
        int n = 0;
        @(negedge clk);
        op = o; is_signed = s; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom); is_signed = 1'($urandom);
        lat = 0;
        busy_hi = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            busy_hi |= in_ready;
        end while (!out_valid && lat < 200);
        res = result;
        dz  = div_zero;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] res, snap;
        logic [32:0] exp;
        logic        dz, busy_hi;
        int          lat, exp_lat, spurious;

        vecs.push_back('{MUL,  1'b0, 32'd7,        32'd6,        32'h0000_002A, 1'b0, NORMAL_LAT});
        vecs.push_back('{MUL,  1'b1, 32'hFFFF_FFF9, 32'd3,       32'hFFFF_FFEB, 1'b0, NORMAL_LAT});
        vecs.push_back('{MULH, 1'b1, 32'hFFFF_FFF9, 32'd3,       32'hFFFF_FFFF, 1'b0, NORMAL_LAT});
        vecs.push_back('{MUL,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, NORMAL_LAT});
        vecs.push_back('{MULH, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, NORMAL_LAT});
        vecs.push_back('{MULH, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, NORMAL_LAT});
        vecs.push_back('{DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 1'b0, NORMAL_LAT});
        vecs.push_back('{REM,  1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 1'b0, NORMAL_LAT});
        vecs.push_back('{DIV,  1'b1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, NORMAL_LAT});
        vecs.push_back('{REM,  1'b1, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 1'b0, NORMAL_LAT});
        vecs.push_back('{DIV,  1'b0, 32'hFFFF_FFF9, 32'd2,       32'h7FFF_FFFC, 1'b0, NORMAL_LAT});
        vecs.push_back('{REM,  1'b0, 32'hFFFF_FFF9, 32'd2,       32'h0000_0001, 1'b0, NORMAL_LAT});
        vecs.push_back('{DIV,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, NORMAL_LAT});
        vecs.push_back('{REM,  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, NORMAL_LAT});
        vecs.push_back('{DIV,  1'b0, 32'd100,      32'd0,        32'hFFFF_FFFF, 1'b1, 1});
        vecs.push_back('{REM,  1'b0, 32'd100,      32'd0,        32'h0000_0064, 1'b1, 1});
        vecs.push_back('{DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1});
        vecs.push_back('{REM,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1});

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result",    64'(result),    64'd0);
        check("reset_div_zero",  64'(div_zero),  64'd0);

        // Directed table.
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, res, dz, lat, busy_hi);
            check($sformatf("vec%0d_result", i),   64'(res),     64'(vecs[i].res));
            check($sformatf("vec%0d_div_zero", i), 64'(dz),      64'(vecs[i].dz));
            check($sformatf("vec%0d_latency", i),  64'(lat),     64'(vecs[i].lat));
            check($sformatf("vec%0d_busy", i),     64'(busy_hi), 64'd0);
        end

        // Randomized ops against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic [1:0]  ro;
            logic        rs;
            logic [31:0] ra, rb;
            ro = 2'($urandom);
            rs = 1'($urandom);
            ra = pick_operand();
            rb = pick_operand();
            exp     = model(ro, rs, ra, rb);
            exp_lat = model_lat(ro, rs, ra, rb);
            do_op(ro, rs, ra, rb, res, dz, lat, busy_hi);
            check($sformatf("rand%0d_result op=%0d s=%0d a=%h b=%h", i, ro, rs, ra, rb), 64'(res), 64'(exp[31:0]));
            check($sformatf("rand%0d_div_zero", i), 64'(dz),  64'(exp[32]));
            check($sformatf("rand%0d_latency", i),  64'(lat), 64'(exp_lat));
        end

        // Backpressure: result held in DONE while a new request waits on in_valid.
        @(negedge clk);
        op = DIV; is_signed = 1'b0; a = 32'd100; b = 32'd0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_early_valid", 64'(out_valid), 64'd1);
        snap = result;
        op = MUL; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_out_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d_result", c),    64'(result),    64'h0000_0000_FFFF_FFFF);
            check($sformatf("bp%0d_stable", c),    64'(result),    64'(snap));
            check($sformatf("bp%0d_div_zero", c),  64'(div_zero),  64'd1);
            check($sformatf("bp%0d_in_ready", c),  64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bubble_out_valid", 64'(out_valid), 64'd0);
        check("bubble_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("bp_accepted_busy",    64'(in_ready), 64'd0);
                check("bp_div_zero_cleared", 64'(div_zero), 64'd0);
            end
        end while (!out_valid && lat < 200);
        check("bp_next_result",  64'(result), 64'h0000_000F);
        check("bp_next_latency", 64'(lat),    64'(NORMAL_LAT));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset in the middle of CALC discards the operation.
        @(negedge clk);
        op = MUL; is_signed = 1'b0; a = 32'h0001_2345; b = 32'h0000_0777; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_reset_in_ready",  64'(in_ready),  64'd1);
        check("mid_reset_out_valid", 64'(out_valid), 64'd0);
        check("mid_reset_result",    64'(result),    64'd0);
        check("mid_reset_div_zero",  64'(div_zero),  64'd0);
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("mid_reset_no_output", 64'(spurious), 64'd0);
        do_op(MUL, 1'b0, 32'd3, 32'd5, res, dz, lat, busy_hi);
        check("post_reset_result",  64'(res), 64'h0000_000F);
        check("post_reset_latency", 64'(lat), 64'(NORMAL_LAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
